// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM state encoding and port identifiers for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester-side bundle for the two arbiter ports (A = CPU, B = loader)
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_done;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_done;
    logic [DATA_W-1:0] b_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_done, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_done, b_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_done, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_done, b_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational two-way winner select (round-robin or fixed priority to A)
module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic i_a_req,
    input  logic i_b_req,
    input  logic i_last,
    output logic o_valid,
    output logic o_port
);

    always_comb begin
        o_valid = i_a_req | i_b_req;
        o_port  = PORT_A;
        if (i_b_req && !i_a_req) begin
            o_port = PORT_B;
        end else if (i_a_req && i_b_req && (RR != 0) && (i_last == PORT_A)) begin
            o_port = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port single-outstanding arbiter onto a tri-state memory bus
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      port,
    output logic              mem_ie,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_bus,
    output logic              o_bus_drv
);

    state_t            r_state;
    state_t            w_next;
    logic              r_port;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_a_done;
    logic              r_b_done;

    logic              w_valid;
    logic              w_port;
    logic              w_latch;
    logic              w_access;
    logic              w_resp;

    rr_pick #(.RR(RR)) u_pick (
        .i_a_req (port.a_req),
        .i_b_req (port.b_req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_port  (w_port)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_access = 1'b0;
        w_resp   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_latch = 1'b1;
                    w_next  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_access = 1'b1;
                w_next   = ST_RESP;
            end
            ST_RESP: begin
                w_resp = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Done is registered off RESP so the pulse lands three edges after the request was sampled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_port    <= PORT_A;
            r_last    <= PORT_B;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
            r_a_done  <= 1'b0;
            r_b_done  <= 1'b0;
        end else begin
            if (w_latch) begin
                r_port  <= w_port;
                r_last  <= w_port;
                r_we    <= (w_port == PORT_A) ? port.a_we    : port.b_we;
                r_addr  <= (w_port == PORT_A) ? port.a_addr  : port.b_addr;
                r_wdata <= (w_port == PORT_A) ? port.a_wdata : port.b_wdata;
            end
            if (w_access && !r_we) begin
                if (r_port == PORT_A) begin
                    r_a_rdata <= mem_bus;
                end else begin
                    r_b_rdata <= mem_bus;
                end
            end
            r_a_done <= w_resp && (r_port == PORT_A);
            r_b_done <= w_resp && (r_port == PORT_B);
        end
    end

    // Write enable is gated by reset directly so a write aborted mid-ACCESS never commits.
    assign mem_ie    = w_access & r_we & rst;
    assign mem_oe    = w_access & ~r_we;
    assign mem_addr  = r_addr;
    assign o_bus_drv = w_access & r_we;
    assign mem_bus   = o_bus_drv ? r_wdata : 8'bzzzz_zzzz;

    assign port.a_done  = r_a_done;
    assign port.a_rdata = r_a_rdata;
    assign port.b_done  = r_b_done;
    assign port.b_rdata = r_b_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with round-robin and fixed-priority instances
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    int         checks;
    int         errors;
    int         contention;

    mem_arbiter_if ifc ();
    mem_arbiter_if ifc0 ();

    logic       mem_ie, mem_oe, bus_drv;
    logic [7:0] mem_addr;
    wire  [7:0] mem_bus;
    logic       mem_ie0, mem_oe0, bus_drv0;
    logic [7:0] mem_addr0;
    wire  [7:0] mem_bus0;

    logic [7:0] mem  [256];
    logic [7:0] mem0 [256];
    logic [7:0] ref_mem [256];

    mem_arbiter #(.RR(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .port      (ifc),
        .mem_ie    (mem_ie),
        .mem_oe    (mem_oe),
        .mem_addr  (mem_addr),
        .mem_bus   (mem_bus),
        .o_bus_drv (bus_drv)
    );

    mem_arbiter #(.RR(0)) dut_fp (
        .clk       (clk),
        .rst       (rst),
        .port      (ifc0),
        .mem_ie    (mem_ie0),
        .mem_oe    (mem_oe0),
        .mem_addr  (mem_addr0),
        .mem_bus   (mem_bus0),
        .o_bus_drv (bus_drv0)
    );

    assign mem_bus  = mem_oe  ? mem[mem_addr]   : 8'bzzzz_zzzz;
    assign mem_bus0 = mem_oe0 ? mem0[mem_addr0] : 8'bzzzz_zzzz;

    always @(negedge clk) begin
        if (mem_ie)  mem[mem_addr]   <= mem_bus;
        if (mem_ie0) mem0[mem_addr0] <= mem_bus0;
    end

    always @(negedge clk) begin
        if (rst) begin
            if ((mem_ie && mem_oe) || (bus_drv && mem_oe) || (ifc.a_done && ifc.b_done))
                contention <= contention + 1;
            if ((mem_ie0 && mem_oe0) || (bus_drv0 && mem_oe0) || (ifc0.a_done && ifc0.b_done))
                contention <= contention + 1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic txn(input logic p, input logic we, input logic [7:0] addr,
                       input logic [7:0] wd, output int lat);
        if (p == 1'b0) begin
            ifc.a_req = 1'b1; ifc.a_we = we; ifc.a_addr = addr; ifc.a_wdata = wd;
        end else begin
            ifc.b_req = 1'b1; ifc.b_we = we; ifc.b_addr = addr; ifc.b_wdata = wd;
        end
        lat = 99;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if ((p == 1'b0 && ifc.a_done) || (p == 1'b1 && ifc.b_done)) begin
                lat = i;
                break;
            end
        end
        if (p == 1'b0) ifc.a_req = 1'b0;
        else           ifc.b_req = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifc.a_req = 1'b1; ifc.a_we = 1'b1; ifc.a_addr = 8'h44; ifc.a_wdata = 8'h99;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (ifc.a_done !== 1'b0 || ifc.b_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_done: a_done=%b b_done=%b required 0/0", ifc.a_done, ifc.b_done);
            end
            checks++;
            if (mem_ie !== 1'b0 || mem_oe !== 1'b0 || bus_drv !== 1'b0) begin
                errors++;
                $display("FAIL reset_mem_ctrl: ie=%b oe=%b drv=%b required 0/0/0", mem_ie, mem_oe, bus_drv);
            end
            checks++;
            if (ifc.a_rdata !== 8'h00 || ifc.b_rdata !== 8'h00 || mem_addr !== 8'h00) begin
                errors++;
                $display("FAIL reset_data: a_rdata=%h b_rdata=%h addr=%h required 00", ifc.a_rdata, ifc.b_rdata, mem_addr);
            end
        end
        ifc.a_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int lat;
        txn(1'b0, 1'b1, 8'h10, 8'h5A, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL single_write_lat: got %0d required 3", lat); end
        checks++;
        if (mem[8'h10] !== 8'h5A) begin errors++; $display("FAIL single_write_mem: got %h required 5a", mem[8'h10]); end
        txn(1'b0, 1'b0, 8'h10, 8'h00, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL single_read_lat: got %0d required 3", lat); end
        checks++;
        if (ifc.a_rdata !== 8'h5A) begin errors++; $display("FAIL single_read_data: got %h required 5a", ifc.a_rdata); end
        checks++;
        if (ifc.b_rdata !== 8'h00) begin errors++; $display("FAIL single_b_rdata_untouched: got %h required 00", ifc.b_rdata); end
    endtask

    task automatic test_tie_rr();
        int lat;
        int seq_p[$];
        int seq_c[$];
        int exp_p[5] = '{0, 1, 0, 1, 0};
        int exp_c[5] = '{3, 6, 9, 12, 15};
        txn(1'b0, 1'b1, 8'h01, 8'hA1, lat);
        txn(1'b1, 1'b1, 8'h02, 8'hB2, lat);
        pulse_reset();
        ifc.a_req = 1'b1; ifc.a_we = 1'b0; ifc.a_addr = 8'h01;
        ifc.b_req = 1'b1; ifc.b_we = 1'b0; ifc.b_addr = 8'h02;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            if (ifc.a_done) begin
                seq_p.push_back(0); seq_c.push_back(c);
                checks++;
                if (ifc.a_rdata !== 8'hA1) begin errors++; $display("FAIL tie_rr_a_rdata: got %h required a1", ifc.a_rdata); end
            end
            if (ifc.b_done) begin
                seq_p.push_back(1); seq_c.push_back(c);
                checks++;
                if (ifc.b_rdata !== 8'hB2) begin errors++; $display("FAIL tie_rr_b_rdata: got %h required b2", ifc.b_rdata); end
            end
            if (c == 15) begin
                ifc.a_req = 1'b0;
                ifc.b_req = 1'b0;
            end
        end
        checks++;
        if (seq_p.size() != 5) begin
            errors++;
            $display("FAIL tie_rr_count: got %0d dones required 5", seq_p.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seq_p[i] != exp_p[i] || seq_c[i] != exp_c[i]) begin
                    errors++;
                    $display("FAIL tie_rr_seq[%0d]: port %0d cycle %0d required port %0d cycle %0d",
                             i, seq_p[i], seq_c[i], exp_p[i], exp_c[i]);
                end
            end
        end
    endtask

    task automatic test_tie_fp();
        int lat;
        pulse_reset();
        ifc0.a_req = 1'b1; ifc0.a_we = 1'b1; ifc0.a_addr = 8'h05; ifc0.a_wdata = 8'h77;
        ifc0.b_req = 1'b1; ifc0.b_we = 1'b1; ifc0.b_addr = 8'h06; ifc0.b_wdata = 8'h66;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            checks++;
            if (ifc0.a_done !== (c % 3 == 0)) begin
                errors++;
                $display("FAIL tie_fp_a_done c%0d: got %b required %b", c, ifc0.a_done, (c % 3 == 0));
            end
            checks++;
            if (ifc0.b_done !== 1'b0) begin
                errors++;
                $display("FAIL tie_fp_b_starved c%0d: got %b required 0", c, ifc0.b_done);
            end
        end
        ifc0.a_req = 1'b0;
        lat = 99;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (ifc0.b_done) begin lat = i; break; end
        end
        ifc0.b_req = 1'b0;
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL tie_fp_b_after_a: latency %0d required 3", lat); end
        checks++;
        if (mem0[8'h05] !== 8'h77 || mem0[8'h06] !== 8'h66) begin
            errors++;
            $display("FAIL tie_fp_mem: got %h/%h required 77/66", mem0[8'h05], mem0[8'h06]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        txn(1'b1, 1'b1, 8'h20, 8'h33, lat);
        ifc.b_req = 1'b1; ifc.b_we = 1'b1; ifc.b_addr = 8'h20; ifc.b_wdata = 8'hFF;
        @(posedge clk); #1;
        checks++;
        if (mem_ie !== 1'b1) begin errors++; $display("FAIL mid_access_ie: got %b required 1", mem_ie); end
        rst = 1'b0;
        ifc.b_req = 1'b0;
        #1;
        checks++;
        if (mem_ie !== 1'b0) begin errors++; $display("FAIL mid_ie_gated: got %b required 0", mem_ie); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (ifc.b_done !== 1'b0) begin errors++; $display("FAIL mid_no_done c%0d: got %b required 0", c, ifc.b_done); end
            @(posedge clk); #1;
        end
        checks++;
        if (mem[8'h20] !== 8'h33) begin errors++; $display("FAIL mid_mem_kept: got %h required 33", mem[8'h20]); end
        txn(1'b1, 1'b1, 8'h21, 8'h44, lat);
        checks++;
        if (lat !== 3 || mem[8'h21] !== 8'h44) begin
            errors++;
            $display("FAIL mid_next_write: lat %0d mem %h required 3/44", lat, mem[8'h21]);
        end
        txn(1'b1, 1'b0, 8'h20, 8'h00, lat);
        checks++;
        if (lat !== 3 || ifc.b_rdata !== 8'h33) begin
            errors++;
            $display("FAIL mid_next_read: lat %0d rdata %h required 3/33", lat, ifc.b_rdata);
        end
    endtask

    task automatic test_random();
        int         mode, mism;
        logic       a_pend, b_pend, aw, bw;
        logic [7:0] aa, ba, ad, bd, a_exp, b_exp;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int t = 0; t < 1000; t++) begin
            mode = $urandom_range(0, 2);
            aw = 1'($urandom_range(0, 1)); bw = 1'($urandom_range(0, 1));
            aa = 8'($urandom); ba = 8'($urandom); ad = 8'($urandom); bd = 8'($urandom);
            ba[7] = ~aa[7];
            a_pend = (mode != 1);
            b_pend = (mode != 0);
            a_exp = ref_mem[aa];
            b_exp = ref_mem[ba];
            if (a_pend) begin ifc.a_req = 1'b1; ifc.a_we = aw; ifc.a_addr = aa; ifc.a_wdata = ad; end
            if (b_pend) begin ifc.b_req = 1'b1; ifc.b_we = bw; ifc.b_addr = ba; ifc.b_wdata = bd; end
            for (int c = 0; c < 12 && (a_pend || b_pend); c++) begin
                @(posedge clk); #1;
                if (a_pend && ifc.a_done) begin
                    a_pend = 1'b0; ifc.a_req = 1'b0;
                    if (aw) ref_mem[aa] = ad;
                    else begin
                        checks++;
                        if (ifc.a_rdata !== a_exp) begin
                            errors++;
                            $display("FAIL rand_a_read t%0d: got %h required %h", t, ifc.a_rdata, a_exp);
                        end
                    end
                end
                if (b_pend && ifc.b_done) begin
                    b_pend = 1'b0; ifc.b_req = 1'b0;
                    if (bw) ref_mem[ba] = bd;
                    else begin
                        checks++;
                        if (ifc.b_rdata !== b_exp) begin
                            errors++;
                            $display("FAIL rand_b_read t%0d: got %h required %h", t, ifc.b_rdata, b_exp);
                        end
                    end
                end
            end
            checks++;
            if (a_pend || b_pend) begin
                errors++;
                $display("FAIL rand_timeout t%0d: pending a=%b b=%b required none", t, a_pend, b_pend);
                ifc.a_req = 1'b0; ifc.b_req = 1'b0;
                repeat (4) @(posedge clk);
                #1;
            end
        end
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        checks++;
        if (mism != 0) begin errors++; $display("FAIL rand_final_mem: %0d bytes differ required 0", mism); end
        checks++;
        if (contention != 0) begin errors++; $display("FAIL bus_contention: %0d events required 0", contention); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        contention = 0;
        rst = 1'b0;
        ifc.a_req = 1'b0; ifc.a_we = 1'b0; ifc.a_addr = 8'h00; ifc.a_wdata = 8'h00;
        ifc.b_req = 1'b0; ifc.b_we = 1'b0; ifc.b_addr = 8'h00; ifc.b_wdata = 8'h00;
        ifc0.a_req = 1'b0; ifc0.a_we = 1'b0; ifc0.a_addr = 8'h00; ifc0.a_wdata = 8'h00;
        ifc0.b_req = 1'b0; ifc0.b_we = 1'b0; ifc0.b_addr = 8'h00; ifc0.b_wdata = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_tie_rr();
        test_tie_fp();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
